ti_tx_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter for the Task Injector's single NoC transmit port.
//  N_SRC internal packet generators (app injection, mapping-complete, task-terminated ...) share the port.
//  - A grant is held from the first to the last flit of a packet, so packets never interleave.
//  - Each transmitted packet is checked for a full HEADER_SIZE header.
//  - Its service word is captured for tracing and debug.

---
 rtl/ti_tx_arbiter_pkg.sv | 17 +
 rtl/ti_rr_arbiter.sv | 31 +++
 rtl/ti_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_ti_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_tx_arbiter_pkg.sv
// Shared types and constants for the Task Injector transmit path.
package ti_tx_arbiter_pkg;

    typedef logic [31:0] flit_t;

    // Every NoC packet starts with a fixed-size header; the service code sits inside it.
    localparam int unsigned HEADER_SIZE         = 13;
    localparam int unsigned DEFAULT_SERVICE_IDX = 2;

    localparam flit_t TASK_ALLOCATION = 32'h0000_0042;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_arb_state_t;

endpackage

// File: rtl/ti_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo N.
module ti_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld
);

    localparam int unsigned IW = $clog2(N);

    int unsigned cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_vld && req[cand[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ti_tx_arbiter.sv
// Packet-granular round-robin arbiter for the Task Injector NoC transmit port.
// Holds a grant for a whole packet, counts header flits and captures the service word.
module ti_tx_arbiter
    import ti_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned SERVICE_IDX = DEFAULT_SERVICE_IDX
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SRC-1:0]           src_valid_i,
    output logic [N_SRC-1:0]           src_ready_o,
    input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
    input  logic [N_SRC-1:0]           src_last_i,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output logic [FLIT_SIZE-1:0]       tx_data_o,
    output logic                       tx_last_o,
    output logic [$clog2(N_SRC)-1:0]   grant_o,
    output logic                       busy_o,
    output logic [31:0]                service_o,
    output logic                       service_vld_o,
    output logic                       hdr_err_o
);

    localparam int unsigned      IW          = $clog2(N_SRC);
    localparam int unsigned      CW          = $clog2(HEADER_SIZE + 1);
    localparam logic [CW-1:0]    CNT_SVC     = CW'(SERVICE_IDX);
    localparam logic [CW-1:0]    CNT_MAX     = CW'(HEADER_SIZE);
    localparam logic [CW-1:0]    CNT_LAST_OK = CW'(HEADER_SIZE - 1);
    localparam logic [IW-1:0]    LAST_IDX    = IW'(N_SRC - 1);

    tx_arb_state_t   state_q, state_d;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [CW-1:0]   flit_cnt_q;
    flit_t           service_q;
    logic            service_vld_q;
    logic            hdr_err_q;
    logic            xfer;

    ti_rr_arbiter #(
        .N (N_SRC)
    ) u_rr_arbiter (
        .req     (src_valid_i),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (pick_vld)              state_d = TX_BUSY;
            TX_BUSY: if (xfer && tx_last_o)     state_d = TX_IDLE;
            default:                            state_d = TX_IDLE;
        endcase
    end

    // Outside BUSY the port is fully quiet, so reset and idle both show all-zero outputs.
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        tx_last_o   = 1'b0;
        src_ready_o = '0;
        if (state_q == TX_BUSY) begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
                if (grant_q == IW'(k)) begin
                    tx_valid_o     = src_valid_i[k];
                    tx_data_o      = src_data_i[k*FLIT_SIZE +: FLIT_SIZE];
                    tx_last_o      = src_last_i[k];
                    src_ready_o[k] = tx_ready_i;
                end
            end
        end
    end

    assign xfer = tx_valid_o & tx_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            flit_cnt_q    <= '0;
            service_q     <= '0;
            service_vld_q <= 1'b0;
            hdr_err_q     <= 1'b0;
        end else begin
            service_vld_q <= 1'b0;
            hdr_err_q     <= 1'b0;
            if (state_q == TX_IDLE) begin
                if (pick_vld) begin
                    grant_q <= pick_idx;
                end
            end else if (xfer) begin
                if (flit_cnt_q == CNT_SVC) begin
                    service_q     <= flit_t'(tx_data_o);
                    service_vld_q <= 1'b1;
                end
                if (tx_last_o) begin
                    // Fewer than HEADER_SIZE flits in total means a truncated header.
                    hdr_err_q  <= (flit_cnt_q < CNT_LAST_OK);
                    rr_ptr_q   <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    flit_cnt_q <= '0;
                end else if (flit_cnt_q != CNT_MAX) begin
                    flit_cnt_q <= flit_cnt_q + 1'b1;
                end
            end
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = (state_q == TX_BUSY);
    assign service_o     = service_q;
    assign service_vld_o = service_vld_q;
    assign hdr_err_o     = hdr_err_q;

endmodule

// File: tb/tb_ti_tx_arbiter.sv
// Directed self-checking bench for ti_tx_arbiter: packet sources are modelled in the bench.
module tb_ti_tx_arbiter;
    import ti_tx_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   src_valid, src_ready, src_last;
    logic [127:0] src_data;
    logic         tx_valid, tx_ready, tx_last;
    logic [31:0]  tx_data;
    logic [1:0]   grant;
    logic         busy;
    logic [31:0]  service;
    logic         service_vld, hdr_err;

    always #5 clk = ~clk;

    ti_tx_arbiter #(.N_SRC(4), .FLIT_SIZE(32), .SERVICE_IDX(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_data_i(src_data), .src_last_i(src_last),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_data_o(tx_data), .tx_last_o(tx_last),
        .grant_o(grant), .busy_o(busy),
        .service_o(service), .service_vld_o(service_vld), .hdr_err_o(hdr_err)
    );

    int total = 0;
    int bad   = 0;

    bit [3:0]    act, hold;
    bit          tog;
    int          len [4];
    int          pos [4];
    int          pktn[4];
    int          npk [4];
    logic [31:0] svc [4];

    logic        s_busy, s_valid, s_last, s_hdr, s_rdy;
    logic [1:0]  s_grant;
    logic [3:0]  s_ready;
    logic [31:0] s_data;
    int          svc_cnt, err_cnt;
    logic [31:0] lg_data[$];
    logic        lg_last[$];
    logic [1:0]  lg_g[$];

    function automatic logic [31:0] flit_of(int k, int p, int n);
        if (p == 2) return svc[k];
        return {4'hA, 4'(k), 8'(n), 16'(p)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            src_valid[k]         = act[k] & ~hold[k];
            src_data[k*32 +: 32] = flit_of(k, pos[k], pktn[k]);
            src_last[k]          = (pos[k] == len[k] - 1);
        end
    endtask

    task automatic cycle();
        logic [3:0] hs;
        if (tog) tx_ready = ~tx_ready;
        else     tx_ready = 1'b1;
        drive();
        @(negedge clk);
        s_busy = busy; s_valid = tx_valid; s_last = tx_last; s_hdr = hdr_err;
        s_grant = grant; s_ready = src_ready; s_data = tx_data; s_rdy = tx_ready;
        if (tx_valid && tx_ready) begin
            lg_data.push_back(tx_data);
            lg_last.push_back(tx_last);
            lg_g.push_back(grant);
        end
        if (service_vld) svc_cnt++;
        if (hdr_err)     err_cnt++;
        hs = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) begin
                if (pos[k] == len[k] - 1) begin
                    pos[k] = 0;
                    pktn[k]++;
                    npk[k]--;
                    if (npk[k] == 0) act[k] = 1'b0;
                end else begin
                    pos[k]++;
                end
            end
        end
    endtask

    task automatic clear_logs();
        lg_data.delete(); lg_last.delete(); lg_g.delete();
        svc_cnt = 0; err_cnt = 0;
    endtask

    task automatic clear_src();
        act = '0; hold = '0; tog = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pos[k] = 0; pktn[k] = 0; npk[k] = 0; len[k] = 13;
            svc[k] = 32'h100 + 32'(k);
        end
        clear_logs();
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add_src(input int k, input int l, input int n);
        act[k] = 1'b1; len[k] = l; npk[k] = n;
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while (act != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 32'(act), 32'd0);
        cycle();
    endtask

    task automatic chk_pkt(input string tag, input int base, input int k, input int n);
        for (int i = 0; i < 13; i++) begin
            chk({tag, "_data"}, lg_data[base+i], flit_of(k, i, n));
            chk({tag, "_grant"}, 32'(lg_g[base+i]), 32'(k));
            chk({tag, "_last"}, 32'(lg_last[base+i]), (i == 12) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int eg[5];
        int en[5];
        clear_src();
        tx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_service", service, 32'd0);
        chk("rst_service_vld", 32'(service_vld), 32'd0);
        chk("rst_hdr_err", 32'(hdr_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single source, full header, service TASK_ALLOCATION
        svc[2] = TASK_ALLOCATION;
        add_src(2, 13, 1);
        run("t1", 100);
        chk("t1_count", 32'(lg_data.size()), 32'd13);
        if (lg_data.size() == 13) begin
            for (int i = 0; i < 13; i++) begin
                chk("t1_data", lg_data[i], (i == 2) ? 32'h42 : {4'hA, 4'd2, 8'd0, 16'(i)});
                chk("t1_grant", 32'(lg_g[i]), 32'd2);
                chk("t1_last", 32'(lg_last[i]), (i == 12) ? 32'd1 : 32'd0);
            end
        end
        chk("t1_service", service, 32'h42);
        chk("t1_svc_pulses", 32'(svc_cnt), 32'd1);
        chk("t1_hdr_err", 32'(err_cnt), 32'd0);
        chk("t1_grant_hold", 32'(grant), 32'd2);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: all sources continuously requesting
        do_reset();
        add_src(0, 13, 2); add_src(1, 13, 1); add_src(2, 13, 1); add_src(3, 13, 1);
        run("t2", 400);
        eg = '{0, 1, 2, 3, 0};
        en = '{0, 0, 0, 0, 1};
        chk("t2_count", 32'(lg_data.size()), 32'd65);
        if (lg_data.size() == 65) begin
            for (int j = 0; j < 5; j++) chk_pkt("t2", 13*j, eg[j], en[j]);
        end
        chk("t2_service", service, 32'h100);
        chk("t2_svc_pulses", 32'(svc_cnt), 32'd5);
        chk("t2_hdr_err", 32'(err_cnt), 32'd0);

        // 3: tx_ready toggling, competing sources 0 and 3, pointer at 1
        clear_src();
        add_src(0, 13, 1); add_src(1, 13, 1); add_src(3, 13, 1);
        tog = 1'b1;
        tx_ready = 1'b1;
        for (int n = 0; n < 200 && act[1]; n++) begin
            cycle();
            chk("t3_src_ready", 32'(s_ready), (s_busy && s_rdy) ? 32'h2 : 32'h0);
        end
        chk("t3_done", 32'(act[1]), 32'd0);
        chk("t3_count", 32'(lg_data.size()), 32'd13);
        if (lg_data.size() == 13) chk_pkt("t3", 0, 1, 0);

        // 4: short packet -> header error, next grant one cycle later
        do_reset();
        add_src(1, 5, 1); add_src(2, 13, 1);
        cycle();
        chk("t4_c0_busy", 32'(s_busy), 32'd0);
        repeat (5) cycle();
        chk("t4_c5_last", 32'(s_last), 32'd1);
        chk("t4_c5_grant", 32'(s_grant), 32'd1);
        chk("t4_c5_hdr", 32'(s_hdr), 32'd0);
        cycle();
        chk("t4_c6_hdr", 32'(s_hdr), 32'd1);
        chk("t4_c6_busy", 32'(s_busy), 32'd0);
        cycle();
        chk("t4_c7_busy", 32'(s_busy), 32'd1);
        chk("t4_c7_grant", 32'(s_grant), 32'd2);
        chk("t4_c7_hdr", 32'(s_hdr), 32'd0);
        chk("t4_c7_data", s_data, 32'hA200_0000);
        run("t4", 100);
        chk("t4_hdr_pulses", 32'(err_cnt), 32'd1);
        chk("t4_count", 32'(lg_data.size()), 32'd18);
        chk("t4_service", service, 32'h102);
        chk("t4_svc_pulses", 32'(svc_cnt), 32'd2);

        // 5: source 0 stalls mid-packet while source 3 waits
        do_reset();
        add_src(0, 13, 1); add_src(3, 13, 1);
        for (int n = 0; n < 50 && pos[0] < 5; n++) cycle();
        chk("t5_reach", 32'(pos[0]), 32'd5);
        hold[0] = 1'b1;
        repeat (10) begin
            cycle();
            chk("t5_hold_grant", 32'(s_grant), 32'd0);
            chk("t5_hold_valid", 32'(s_valid), 32'd0);
            chk("t5_hold_ready", 32'(s_ready), 32'h1);
        end
        hold[0] = 1'b0;
        run("t5", 200);
        chk("t5_count", 32'(lg_data.size()), 32'd26);
        if (lg_data.size() == 26) begin
            chk_pkt("t5a", 0, 0, 0);
            chk_pkt("t5b", 13, 3, 0);
        end

        // 6: reset at flit 7
        do_reset();
        add_src(1, 13, 1);
        for (int n = 0; n < 50 && pos[1] < 7; n++) cycle();
        chk("t6_reach", 32'(pos[1]), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_rst_tx_data", tx_data, 32'd0);
        chk("t6_rst_tx_last", 32'(tx_last), 32'd0);
        chk("t6_rst_src_ready", 32'(src_ready), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_service", service, 32'd0);
        chk("t6_rst_hdr_err", 32'(hdr_err), 32'd0);
        pos[1] = 0;
        add_src(0, 13, 1);
        clear_logs();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("t6", 200);
        chk("t6_count", 32'(lg_data.size()), 32'd26);
        if (lg_data.size() == 26) begin
            chk_pkt("t6a", 0, 0, 0);
            chk_pkt("t6b", 13, 1, 0);
        end
        chk("t6_hdr_err", 32'(err_cnt), 32'd0);
        chk("t6_svc_pulses", 32'(svc_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
